// File: rtl/recipe_seq_pkg.sv
// Purpose : shared types and defaults for the recipe sequencer (state enum, default sizes, legacy recipe masks).
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Ingredient indices of the legacy coffee maker: water=0, coffee=1, milk=2, choco=3, sugar=4.
package recipe_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int NUM_ING_DEF     = 5;
    localparam int NUM_RECIPES_DEF = 4;

    localparam int ING_WATER  = 0;
    localparam int ING_COFFEE = 1;
    localparam int ING_MILK   = 2;
    localparam int ING_CHOCO  = 3;
    localparam int ING_SUGAR  = 4;

    // Legacy recipes: 0 = water+coffee+sugar, 1/2 = +milk, 3 = +milk+choco.
    localparam logic [NUM_ING_DEF-1:0] LEGACY_MASK_0 = 5'b10011;
    localparam logic [NUM_ING_DEF-1:0] LEGACY_MASK_1 = 5'b10111;
    localparam logic [NUM_ING_DEF-1:0] LEGACY_MASK_2 = 5'b10111;
    localparam logic [NUM_ING_DEF-1:0] LEGACY_MASK_3 = 5'b11111;

    // Packed in recipe_mask port order: recipe r occupies bits [r*NUM_ING +: NUM_ING].
    localparam logic [NUM_RECIPES_DEF*NUM_ING_DEF-1:0] LEGACY_RECIPE_MASKS =
        {LEGACY_MASK_3, LEGACY_MASK_2, LEGACY_MASK_1, LEGACY_MASK_0};

endpackage

// File: rtl/next_ing_finder.sv
// Purpose : priority encoder returning the lowest set bit of mask above cur (or from bit 0 when from_start).
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : mask/cur/from_start in; found (a candidate exists) and idx (its index) out.
module next_ing_finder
    import recipe_seq_pkg::*;
#(
    parameter int NUM_ING = NUM_ING_DEF,
    parameter int IW      = $clog2(NUM_ING)
) (
    input  logic [NUM_ING-1:0] mask,
    input  logic [IW-1:0]      cur,
    input  logic               from_start,
    output logic               found,
    output logic [IW-1:0]      idx
);

    // Scan from the top down so the last hit written is the lowest eligible bit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_ING - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/recipe_sequencer.sv
// Purpose : steps through the enabled ingredient valves of a selected recipe, one timer handshake per valve.
// Latency : ok -> first valve 1 cycle; per ingredient 1 (LOAD) + T + 1 cycles; last t_expired -> done 1 cycle.
// Backpressure: ok ignored while busy; t_expired honoured only in DISPENSE.
// Ports   : clk/reset (sync, active-high); ok, c_type, recipe_mask, t_expired, cancel in;
//           ing_type, start_timer, ingredientes (one-hot valves), busy, done out (all registered).
// Build option: define RECIPE_SEQ_CANCEL_EN to let cancel abort a running recipe; otherwise cancel is ignored.
module recipe_sequencer
    import recipe_seq_pkg::*;
#(
    parameter int NUM_ING     = NUM_ING_DEF,
    parameter int NUM_RECIPES = NUM_RECIPES_DEF,
    parameter int IW          = $clog2(NUM_ING),
    parameter int RW          = $clog2(NUM_RECIPES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ok,
    input  logic [RW-1:0]                  c_type,
    input  logic [NUM_RECIPES*NUM_ING-1:0] recipe_mask,
    input  logic                           t_expired,
    input  logic                           cancel,
    output logic [IW-1:0]                  ing_type,
    output logic                           start_timer,
    output logic [NUM_ING-1:0]             ingredientes,
    output logic                           busy,
    output logic                           done
);

`ifdef RECIPE_SEQ_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    localparam logic [NUM_ING-1:0] ONE_HOT_0 = {{(NUM_ING-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [IW-1:0]      cur_q, cur_d;
    logic [NUM_ING-1:0] mask_q, mask_d;
    logic [NUM_ING-1:0] sel_mask;
    logic [NUM_ING-1:0] find_mask;
    logic               find_from_start;
    logic               find_found;
    logic [IW-1:0]      find_idx;
    logic               cancel_req;

    logic [IW-1:0]      ing_type_d;
    logic               start_timer_d;
    logic [NUM_ING-1:0] ingredientes_d;
    logic               busy_d;
    logic               done_d;

    assign cancel_req = CANCEL_EN & cancel;

    // Recipe lookup; a select beyond NUM_RECIPES matches nothing and yields an empty mask.
    always_comb begin
        sel_mask = '0;
        for (int r = 0; r < NUM_RECIPES; r++) begin
            if (int'(c_type) == r) begin
                sel_mask = recipe_mask[r*NUM_ING +: NUM_ING];
            end
        end
    end

    // One encoder serves both searches: inclusive on the fresh mask in IDLE,
    // strictly above cur on the latched mask while dispensing.
    assign find_from_start = (state_q == ST_IDLE);
    assign find_mask       = (state_q == ST_IDLE) ? sel_mask : mask_q;

    next_ing_finder #(
        .NUM_ING (NUM_ING),
        .IW      (IW)
    ) u_finder (
        .mask       (find_mask),
        .cur        (cur_q),
        .from_start (find_from_start),
        .found      (find_found),
        .idx        (find_idx)
    );

    // Next state plus the output values that go with it; outputs are then
    // registered so they describe the state entered on the same edge.
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        mask_d         = mask_q;
        ing_type_d     = ing_type;
        ingredientes_d = ingredientes;
        start_timer_d  = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ok) begin
                    mask_d = sel_mask;
                    if (find_found) begin
                        state_d        = ST_LOAD;
                        cur_d          = find_idx;
                        ing_type_d     = find_idx;
                        ingredientes_d = ONE_HOT_0 << find_idx;
                    end else begin
                        state_d        = ST_DONE;
                        ingredientes_d = '0;
                        done_d         = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (cancel_req) begin
                    state_d        = ST_DONE;
                    ingredientes_d = '0;
                    done_d         = 1'b1;
                end else begin
                    state_d       = ST_DISPENSE;
                    start_timer_d = 1'b1;
                end
            end
            ST_DISPENSE: begin
                // Cancel wins over a simultaneous expiry.
                if (cancel_req) begin
                    state_d        = ST_DONE;
                    ingredientes_d = '0;
                    done_d         = 1'b1;
                end else if (t_expired) begin
                    if (find_found) begin
                        state_d        = ST_LOAD;
                        cur_d          = find_idx;
                        ing_type_d     = find_idx;
                        ingredientes_d = ONE_HOT_0 << find_idx;
                    end else begin
                        state_d        = ST_DONE;
                        ingredientes_d = '0;
                        done_d         = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d        = ST_IDLE;
                ingredientes_d = '0;
            end
            default: begin
                state_d        = ST_IDLE;
                ingredientes_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            mask_q       <= '0;
            ing_type     <= '0;
            start_timer  <= 1'b0;
            ingredientes <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            mask_q       <= mask_d;
            ing_type     <= ing_type_d;
            start_timer  <= start_timer_d;
            ingredientes <= ingredientes_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_recipe_sequencer.sv
`timescale 1ns/1ps
module tb_recipe_sequencer;

    localparam int NI = 5;
    localparam int NR = 4;
    localparam int IW = 3;
    localparam int RW = 2;
    localparam int MW = NI * NR;

`ifdef RECIPE_SEQ_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ok;
    logic [RW-1:0] c_type;
    logic [MW-1:0] recipe_mask;
    logic          t_expired;
    logic          cancel;
    logic [IW-1:0] ing_type;
    logic          start_timer;
    logic [NI-1:0] ingredientes;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    recipe_sequencer #(
        .NUM_ING     (NI),
        .NUM_RECIPES (NR),
        .IW          (IW),
        .RW          (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ok           (ok),
        .c_type       (c_type),
        .recipe_mask  (recipe_mask),
        .t_expired    (t_expired),
        .cancel       (cancel),
        .ing_type     (ing_type),
        .start_timer  (start_timer),
        .ingredientes (ingredientes),
        .busy         (busy),
        .done         (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Per-run configuration
    int t_cfg [NI];
    bit cfg_noise;
    int cfg_cancel_after;
    int cfg_reset_on;

    // Per-run observations
    int obs_seq [$];
    int obs_start [$];
    int obs_done_edge;
    int obs_done_cnt;
    int obs_valve_err;
    bit obs_reset_hit;

    localparam logic [MW-1:0] LEGACY = 20'b11111_10111_10111_10011;
    localparam logic [MW-1:0] CUSTOM = 20'b11111_01010_10000_00001;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    // Starts a recipe, plays the timer block and records what the sequencer did.
    // Edge 1 is the edge that samples ok.
    task automatic run_recipe(input logic [RW-1:0] ct, input logic [MW-1:0] masks);
        int  n;
        int  cnt;
        bit  tact;
        bit  fin;
        obs_seq.delete();
        obs_start.delete();
        obs_done_edge = -1;
        obs_done_cnt  = 0;
        obs_valve_err = 0;
        obs_reset_hit = 1'b0;
        c_type      = ct;
        recipe_mask = masks;
        ok          = 1'b1;
        n    = 0;
        cnt  = 0;
        tact = 1'b0;
        fin  = 1'b0;
        for (int b = 0; b < 200 && !fin; b++) begin
            @(posedge clk);
            #1;
            n++;
            ok        = 1'b0;
            t_expired = 1'b0;
            cancel    = 1'b0;
            if (cfg_noise && busy && !done) begin
                ok          = 1'($urandom_range(0, 1));
                c_type      = RW'($urandom);
                recipe_mask = MW'($urandom);
            end
            if (done) begin
                obs_done_cnt++;
                if (ingredientes != '0) obs_valve_err++;
            end else if (!busy) begin
                obs_valve_err++;
            end else if (ingredientes != (NI'(1) << ing_type)) begin
                obs_valve_err++;
            end
            if (start_timer) begin
                obs_seq.push_back(int'(ing_type));
                obs_start.push_back(n);
                tact = 1'b1;
                cnt  = (int'(ing_type) < NI) ? t_cfg[ing_type] : 0;
                if (int'(ing_type) == cfg_reset_on) begin
                    // reset must override every other request in the same cycle
                    reset     = 1'b1;
                    ok        = 1'b1;
                    t_expired = 1'b1;
                    cancel    = 1'b1;
                    @(posedge clk);
                    #1;
                    reset     = 1'b0;
                    ok        = 1'b0;
                    t_expired = 1'b0;
                    cancel    = 1'b0;
                    check("reset_mid_recipe_outputs",
                          int'({ing_type, start_timer, ingredientes, busy, done}), 0);
                    obs_reset_hit = 1'b1;
                    fin = 1'b1;
                end
            end
            if (!fin && done) begin
                obs_done_edge = n;
                fin = 1'b1;
            end
            if (!fin) begin
                if (tact) begin
                    if (cnt == 0) begin
                        t_expired = 1'b1;
                        tact      = 1'b0;
                        if (obs_seq.size() - 1 == cfg_cancel_after) cancel = 1'b1;
                    end else begin
                        cnt--;
                    end
                end else if (cfg_noise && busy) begin
                    t_expired = 1'b1;  // stray expiry while in LOAD
                end
            end
        end
        ok        = 1'b0;
        t_expired = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic gap_and_check_idle(input string name);
        ok        = 1'b0;
        t_expired = 1'b1;  // stray expiry / cancel in DONE and IDLE must be ignored
        cancel    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        t_expired = 1'b0;
        cancel    = 1'b0;
        check(name, int'({busy, done, start_timer, ingredientes}), 0);
    endtask

    typedef struct {
        logic [RW-1:0] ct;
        logic [MW-1:0] masks;
        int            t;
        bit            noise;
        int            cancel_after;
        int            exp_k;
        logic [19:0]   exp_seq;   // nibble j = j-th dispensed index
        int            exp_done;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        int exp_q [$];
        int exp_st [$];
        int e;
        int exp_done;
        int k;
        int errs;
        logic [NI-1:0] m;
        logic [MW-1:0] mk;
        logic [RW-1:0] ct;
        logic [19:0]   sq;

        vecs[0] = '{2'd0, LEGACY, 3, 1'b0, -1, 3, 20'h00410, 16};
        vecs[1] = '{2'd3, LEGACY, 3, 1'b0, -1, 5, 20'h43210, 26};
        vecs[2] = '{2'd1, LEGACY, 0, 1'b1, -1, 4, 20'h04210, 9};
        vecs[3] = '{2'd2, {LEGACY[19:15], 5'b00000, LEGACY[9:0]}, 2, 1'b0, -1, 0, 20'h00000, 1};
        vecs[4] = '{2'd0, CUSTOM, 1, 1'b0, -1, 1, 20'h00000, 4};
        vecs[5] = '{2'd1, CUSTOM, 2, 1'b1, -1, 1, 20'h00004, 5};
        vecs[6] = '{2'd2, CUSTOM, 1, 1'b1, -1, 2, 20'h00031, 7};
        if (CANCEL_EN)
            vecs[7] = '{2'd3, LEGACY, 2, 1'b0, 1, 2, 20'h00010, 9};
        else
            vecs[7] = '{2'd3, LEGACY, 2, 1'b0, 1, 5, 20'h43210, 21};
        vecs[8] = '{2'd0, LEGACY, 0, 1'b1, -1, 3, 20'h00410, 7};

        // Reset with every request input active
        reset       = 1'b1;
        ok          = 1'b1;
        t_expired   = 1'b1;
        cancel      = 1'b1;
        c_type      = '0;
        recipe_mask = LEGACY;
        cfg_noise        = 1'b0;
        cfg_cancel_after = -1;
        cfg_reset_on     = -1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'({ing_type, start_timer, ingredientes, busy, done}), 0);
        reset     = 1'b0;
        ok        = 1'b0;
        t_expired = 1'b0;
        cancel    = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", int'({busy, done}), 0);

        // Table-driven recipes
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < NI; i++) t_cfg[i] = vecs[v].t;
            cfg_noise        = vecs[v].noise;
            cfg_cancel_after = vecs[v].cancel_after;
            cfg_reset_on     = -1;
            run_recipe(vecs[v].ct, vecs[v].masks);
            check($sformatf("vec%0d_count", v), obs_seq.size(), vecs[v].exp_k);
            sq = vecs[v].exp_seq;
            for (int j = 0; j < vecs[v].exp_k; j++)
                check($sformatf("vec%0d_idx%0d", v, j),
                      (j < obs_seq.size()) ? obs_seq[j] : -1, int'(sq[j*4 +: 4]));
            check($sformatf("vec%0d_done_edge", v), obs_done_edge, vecs[v].exp_done);
            check($sformatf("vec%0d_done_pulses", v), obs_done_cnt, 1);
            check($sformatf("vec%0d_valves", v), obs_valve_err, 0);
            gap_and_check_idle($sformatf("vec%0d_idle", v));
        end

        // Reset during DISPENSE of index 2, then a clean restart
        for (int i = 0; i < NI; i++) t_cfg[i] = 1;
        cfg_noise        = 1'b0;
        cfg_cancel_after = -1;
        cfg_reset_on     = 2;
        run_recipe(2'd3, LEGACY);
        check("rst_hit", int'(obs_reset_hit), 1);
        check("rst_count_before", obs_seq.size(), 3);
        check("rst_no_done", obs_done_cnt, 0);
        cfg_reset_on = -1;
        for (int i = 0; i < NI; i++) t_cfg[i] = 0;
        run_recipe(2'd3, LEGACY);
        check("restart_first_idx", (obs_seq.size() > 0) ? obs_seq[0] : -1, 0);
        check("restart_count", obs_seq.size(), 5);
        check("restart_done_edge", obs_done_edge, 11);
        gap_and_check_idle("restart_idle");

        // Randomized recipes against a reference model
        for (int it = 0; it < 40; it++) begin
            mk = MW'($urandom);
            ct = RW'($urandom);
            if ($urandom_range(0, 4) == 0) mk[ct*NI +: NI] = '0;
            for (int i = 0; i < NI; i++) t_cfg[i] = $urandom_range(0, 4);
            cfg_noise        = 1'($urandom_range(0, 1));
            cfg_cancel_after = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            cfg_reset_on     = -1;

            m = mk[ct*NI +: NI];
            exp_q.delete();
            exp_st.delete();
            for (int i = 0; i < NI; i++) if (m[i]) exp_q.push_back(i);
            if (CANCEL_EN && cfg_cancel_after >= 0 && cfg_cancel_after < exp_q.size())
                while (exp_q.size() > cfg_cancel_after + 1) void'(exp_q.pop_back());
            e = 1;
            foreach (exp_q[j]) begin
                exp_st.push_back(e + 1);
                e += t_cfg[exp_q[j]] + 2;
            end
            exp_done = e;

            run_recipe(ct, mk);
            k = exp_q.size();
            check($sformatf("rnd%0d_count", it), obs_seq.size(), k);
            errs = 0;
            for (int j = 0; j < k; j++) begin
                if (j >= obs_seq.size() || obs_seq[j] != exp_q[j]) errs++;
                if (j >= obs_start.size() || obs_start[j] != exp_st[j]) errs++;
            end
            check($sformatf("rnd%0d_order_timing_errs", it), errs, 0);
            check($sformatf("rnd%0d_done_edge", it), obs_done_edge, exp_done);
            check($sformatf("rnd%0d_done_pulses", it), obs_done_cnt, 1);
            check($sformatf("rnd%0d_valves", it), obs_valve_err, 0);
            gap_and_check_idle($sformatf("rnd%0d_idle", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/recipe_sequencer.md
# recipe_sequencer

Parametrised successor to the coffee-maker dispense FSM. Sequences up to `NUM_ING` ingredient valves for one of `NUM_RECIPES` selectable recipes, each recipe defined by a run-time ingredient mask. It hands each step to the external dispense timer via a `start_timer`/`t_expired` handshake and really waits for expiry. It sits between the front-panel controls (`ok`, `c_type`) and the valve drivers / timer block.

## Interface
- `NUM_ING`, 5: number of ingredients/valves (≥2).
- `NUM_RECIPES`, 4: number of selectable recipes (≥2).
- `IW`, `$clog2(NUM_ING)`: width of the ingredient index.
- `RW`, `$clog2(NUM_RECIPES)`: width of the recipe select.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ok` in 1: start request; sampled only in IDLE.
- `c_type` in RW: recipe select; latched on accepted `ok`.
- `recipe_mask` in NUM_RECIPES*NUM_ING:
  - bits [r*NUM_ING +: NUM_ING] = ingredients used by recipe r.
  - Bit i means ingredient i is dispensed.
  - Latched on accepted `ok`.
- `t_expired` in 1: timer done; valid only in DISPENSE.
- `cancel` in 1: abort request (see Configuration).
- `ing_type` out IW: index of the current ingredient.
- `start_timer` out 1: one-cycle pulse that starts the dispense timer.
- `ingredientes` out NUM_ING: one-hot valve enables, all-zero when no valve is open.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a recipe completes or aborts.

## Operation
- States: IDLE, LOAD, DISPENSE, DONE.
- IDLE:
  - On `ok`=1, latch `mask = recipe_mask[c_type]`.
  - If `mask`≠0, go to LOAD with `cur` = lowest set bit.
  - If `mask`=0, go to DONE.
- LOAD:
  - `ing_type`=`cur`, `ingredientes`=1<<`cur`, `start_timer`=0.
  - Always advances to DISPENSE after one cycle.
- DISPENSE:
  - On entry, `start_timer`=1 for exactly one cycle.
  - `ingredientes` is held until `t_expired`.
  - On `t_expired`, `next` = lowest set bit of `mask` strictly above `cur`.
  - If `next` exists, go to LOAD. Otherwise go to DONE.
- DONE: `ingredientes`=0, `done`=1 for one cycle, then go to IDLE.
- Ingredients are always dispensed in ascending index order, each exactly once.
- `c_type` ≥ `NUM_RECIPES` is treated as an all-zero mask.
- `ok` while `busy` is ignored.
- `t_expired` outside DISPENSE is ignored.
- `t_expired` in the same cycle as the `start_timer` pulse counts as expiry.

## Timing
- All outputs are registered and reflect the state entered on that edge.
- Reset values: state=IDLE, `ing_type`=0, `start_timer`=0, `ingredientes`=0, `busy`=0, `done`=0, `cur`=0, `mask`=0.
- `reset` mid-recipe closes all valves on the next edge; no `done` pulse is issued.
- `reset` overrides `ok`, `cancel` and `t_expired` in the same cycle.
- Latency with k enabled ingredients and T_i cycles from `start_timer` to `t_expired` for ingredient i:
  - `ok` edge → first valve open: 1 cycle.
  - Each ingredient costs 1 (LOAD) + T_i + 1 cycles.
  - Last `t_expired` → `done`: 1 cycle.
- Empty mask: `done` is asserted 1 cycle after `ok`.

## Configuration
- Macro `RECIPE_SEQ_CANCEL_EN`.
- Defined:
  - `cancel`=1 in LOAD or DISPENSE goes to DONE next edge: valves close and `done` pulses.
  - `cancel` has priority over a simultaneous `t_expired`.
  - `cancel` in IDLE or DONE is ignored.
- Undefined: the `cancel` port exists but is ignored, and every recipe runs to completion.

## Structure
- Package `recipe_seq_pkg` holds:
  - the state enum;
  - the default parameter values;
  - localparam default masks for the legacy recipes: ingredient indices water=0, coffee=1, milk=2, choco=3, sugar=4.
  - Legacy recipe masks: 0 = water+coffee+sugar = 5'b10011; 1, 2 = +milk = 5'b10111; 3 = +milk+choco = 5'b11111.
- Sub-module `next_ing_finder`:
  - Combinational priority encoder.
  - Inputs `mask` and `cur`; `from_start` makes the search inclusive of bit 0.
  - Outputs `found` and `idx`.
- The sequencer FSM itself is a single module.

## Test plan
- Legacy recipe 0 (mask 5'b10011), `ok` pulse, `t_expired` 3 cycles after each `start_timer` → `ing_type` sequence 0,1,4; exactly 3 `start_timer` pulses; `done` 1 cycle after the third expiry.
- Recipe 3 (mask 5'b11111) → indices 0,1,2,3,4 in order; `ingredientes` one-hot and matching `ing_type` throughout.
- Mask 0 → `done` 1 cycle after `ok`; `start_timer` never asserts; `ingredientes` stays 0.
- `reset` during DISPENSE of index 2 → next cycle all outputs at reset values; a new `ok` restarts from index 0.
- `ok` re-pulsed while busy and stray `t_expired` in LOAD → both ignored; the sequence is unchanged.
- With `RECIPE_SEQ_CANCEL_EN`: `cancel` with simultaneous `t_expired` in DISPENSE → DONE next edge, no further `start_timer`. Without the macro, the same stimulus completes the full recipe.
